// File: rtl/memoria_pkg.sv
// Shared encodings for the memoria RAM controller: mode values and FSM states.
package memoria_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_FILL   = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_SCAN = 2'b10
    } state_e;

endpackage

// File: rtl/memoria_ram_core.sv
// Single-port synchronous RAM with registered, write-through read port.
// Contents are never cleared; only the output register is reset.
module memoria_ram_core #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (we_i) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memoria_ram_ctrl.sv
// RAM controller with manual access, pattern fill and timed address scan.
// Optional stored even parity per word when MEMORIA_PARITY_EN is defined.
//
// state | meaning
// IDLE  | switches drive the RAM directly (address, wren, data)
// FILL  | writes base+a to every address a, one word per cycle
// SCAN  | reads cur_addr, advancing every SCAN_DIV cycles with wrap
module memoria_ram_ctrl
    import memoria_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 25_000_000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [1:0]        mode_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wren_i,
    output logic [DATA_W-1:0] q_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              parity_err_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCAN_DIV - 1);
`ifdef MEMORIA_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] word_wdata;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        div_d      = div_q;
        done_d     = 1'b0;
        ram_addr   = address_i;
        ram_we     = wren_i;
        word_wdata = data_i;
        case (state_q)
            ST_IDLE: begin
                if (start_i && mode_i == MODE_FILL) begin
                    state_d = ST_FILL;
                    addr_d  = '0;
                    base_d  = data_i;
                end else if (start_i && mode_i == MODE_SCAN) begin
                    state_d = ST_SCAN;
                    addr_d  = address_i;
                    div_d   = DIV_RELOAD;
                end
            end
            ST_FILL: begin
                ram_addr   = addr_q;
                ram_we     = 1'b1;
                word_wdata = base_q + DATA_W'(addr_q);
                if (addr_q == '1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_SCAN: begin
                ram_addr = addr_q;
                ram_we   = 1'b0;
                if (start_i || mode_i != MODE_SCAN) begin
                    state_d = ST_IDLE;
                end else if (div_q == '0) begin
                    div_d  = DIV_RELOAD;
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes are blocked while reset is held so an aborted fill leaves no stray word.
`ifdef MEMORIA_PARITY_EN
    assign mem_wdata    = {^word_wdata, word_wdata};
    assign q_o          = mem_rdata[DATA_W-1:0];
    assign parity_err_o = mem_rdata[DATA_W] ^ (^mem_rdata[DATA_W-1:0]);
`else
    assign mem_wdata    = word_wdata;
    assign q_o          = mem_rdata;
    assign parity_err_o = 1'b0;
`endif

    memoria_ram_core #(
        .WORD_W (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .we_i    (ram_we & ~reset_i),
        .addr_i  (ram_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign cur_addr_o = ram_addr;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_memoria_ram_ctrl.sv
// Scoreboard bench for memoria_ram_ctrl (DATA_W=8, ADDR_W=5, SCAN_DIV=4).
module tb_memoria_ram_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       start;
    logic [4:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;
    logic [4:0] cur_addr;
    logic       busy;
    logic       done;
    logic       parity_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [32];
    logic [7:0] want;

    memoria_ram_ctrl #(.DATA_W(8), .ADDR_W(5), .SCAN_DIV(4)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .mode_i       (mode),
        .start_i      (start),
        .address_i    (address),
        .data_i       (data),
        .wren_i       (wren),
        .q_o          (q),
        .cur_addr_o   (cur_addr),
        .busy_o       (busy),
        .done_o       (done),
        .parity_err_o (parity_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_read(input logic [4:0] a, input logic [7:0] e);
        mode    = 2'b00;
        start   = 1'b0;
        wren    = 1'b0;
        address = a;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 2'b00; start = 1'b0; address = '0; data = '0; wren = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h want=00", q); end
        checks++; if (cur_addr !== 5'h00) begin errors++; $display("FAIL reset_cur_addr got=%h want=00", cur_addr); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b want=0", parity_err); end
        reset = 1'b0;
    endtask

    task automatic test_manual();
        address = 5'h03; data = 8'hA5; wren = 1'b1;
        exp_q.push_back(8'hA5); model[3] = 8'hA5;
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL manual_write_through got=%h want=%h", q, want); end
        address = 5'h07; data = 8'h3C; wren = 1'b1;
        exp_q.push_back(8'h3C); model[7] = 8'h3C;
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL manual_write_through2 got=%h want=%h", q, want); end
        push_read(5'h03, 8'hA5);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL manual_read3 got=%h want=%h", q, want); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL manual_parity got=%b want=0", parity_err); end
        push_read(5'h07, 8'h3C);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL manual_read7 got=%h want=%h", q, want); end
    endtask

    task automatic test_ignored_start();
        mode = 2'b11; start = 1'b1; tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_mode11 busy got=%b want=0", busy); end
        mode = 2'b00; start = 1'b1; tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_manual busy got=%b want=0", busy); end
    endtask

    task automatic test_fill();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [4:0] addrs [4] = '{5'd0, 5'd15, 5'd16, 5'd31};
        logic [7:0] vals  [4] = '{8'hF0, 8'hFF, 8'h00, 8'h0F};
        mode = 2'b01; data = 8'hF0; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00; data = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_done_busy got=%b want=0", busy); end
            end
            tick();
        end
        checks++; if (busy_cnt != 32) begin errors++; $display("FAIL fill_busy_cycles got=%0d want=32", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL fill_done_pulses got=%0d want=1", done_cnt); end
        for (int a = 0; a < 32; a++) model[a] = 8'hF0 + 8'(a);
        for (int k = 0; k < 4; k++) begin
            push_read(addrs[k], vals[k]);
            tick();
            want = exp_q.pop_front();
            checks++; if (q !== want) begin errors++; $display("FAIL fill_read addr=%0d got=%h want=%h", addrs[k], q, want); end
        end
    endtask

    task automatic test_scan();
        int waited = 0;
        logic [4:0] seq [12] = '{5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1F, 5'h1F, 5'h1F, 5'h1F,
                                 5'h00, 5'h00, 5'h00, 5'h00};
        mode = 2'b01; data = 8'h00; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00;
        while (done !== 1'b1 && waited < 40) begin tick(); waited++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL scan_prefill_done got=%b want=1", done); end
        for (int a = 0; a < 32; a++) model[a] = 8'(a);
        mode = 2'b10; address = 5'h1E; start = 1'b1;
        exp_q.push_back(model[5'h1E]);
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++; if (cur_addr !== seq[k]) begin errors++; $display("FAIL scan_cur_addr step=%0d got=%h want=%h", k, cur_addr, seq[k]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy step=%0d got=%b want=1", k, busy); end
            want = exp_q.pop_front();
            checks++; if (q !== want) begin errors++; $display("FAIL scan_q step=%0d got=%h want=%h", k, q, want); end
            exp_q.push_back(model[seq[k]]);
            tick();
        end
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL scan_q_last got=%h want=%h", q, want); end
        start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_exit busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_fill();
        int done_seen = 0;
        mode = 2'b01; data = 8'h10; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00; address = 5'h00;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        if (done === 1'b1) done_seen++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_q got=%h want=00", q); end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_done_pulses got=%0d want=0", done_seen); end
        push_read(5'd9, 8'h19);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL abort_read9 got=%h want=%h", q, want); end
        push_read(5'd10, 8'h0A);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL abort_read10 got=%h want=%h", q, want); end
        push_read(5'd31, 8'h1F);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL abort_read31 got=%h want=%h", q, want); end
    endtask

    task automatic test_wren_busy();
        int waited = 0;
        mode = 2'b01; data = 8'h40; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00;
        address = 5'h02; data = 8'h99; wren = 1'b1;
        repeat (10) tick();
        wren = 1'b0; mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0; mode = 2'b00;
        while (done !== 1'b1 && waited < 40) begin tick(); waited++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_fill_done got=%b want=1", done); end
        push_read(5'h02, 8'h42);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL busy_wren_read2 got=%h want=%h", q, want); end
        push_read(5'h1F, 8'h5F);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL busy_fill_read31 got=%h want=%h", q, want); end
    endtask

`ifdef MEMORIA_PARITY_EN
    task automatic test_parity();
        address = 5'h04; data = 8'h07; wren = 1'b1;
        tick();
        push_read(5'h04, 8'h07);
        tick();
        want = exp_q.pop_front();
        checks++; if (q !== want) begin errors++; $display("FAIL parity_clean_q got=%h want=%h", q, want); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean got=%b want=0", parity_err); end
        dut.u_core.mem_q[4][8] = ~dut.u_core.mem_q[4][8];
        push_read(5'h04, 8'h07);
        tick();
        want = exp_q.pop_front();
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_flipped got=%b want=1", parity_err); end
        checks++; if (q !== want) begin errors++; $display("FAIL parity_flipped_q got=%h want=%h", q, want); end
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_ignored_start();
        test_fill();
        test_scan();
        test_reset_mid_fill();
        test_wren_busy();
`ifdef MEMORIA_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
